// File: rtl/mc_ctrl_fsm_if.sv
// Control-to-datapath/memory bundle for the multi-cycle RV32I controller.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_fsm_if;
   logic [31:0] instr;
   logic        alu_zero;
   logic        alu_lsb;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        mem_iord;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic [3:0]  alu_ctrl;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic        aluout_we;
   logic        rf_we;
   logic [1:0]  wb_sel;

   modport master (
      input  instr, alu_zero, alu_lsb, mem_ready,
      output mem_req, mem_we, mem_iord, ir_we, pc_we, pc_src, alu_ctrl,
             alu_src_a, alu_src_b, aluout_we, rf_we, wb_sel
   );

   modport slave (
      output instr, alu_zero, alu_lsb, mem_ready,
      input  mem_req, mem_we, mem_iord, ir_we, pc_we, pc_src, alu_ctrl,
             alu_src_a, alu_src_b, aluout_we, rf_we, wb_sel
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB, drives ALU/operand
// selects and datapath write enables, and watches memory for stalls that never end.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   mc_ctrl_fsm_if.master       bus,
   output logic                err_o,
   output logic [2:0]          state_o
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_ERR = 3'd7;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ZERO = 4'h0;
   localparam logic [3:0] ALU_ADD  = 4'h1;
   localparam logic [3:0] ALU_SUB  = 4'h2;
   localparam logic [3:0] ALU_PASSB = 4'h3;
   localparam logic [3:0] ALU_SLT  = 4'h4;
   localparam logic [3:0] ALU_SLTU = 4'h5;
   localparam logic [3:0] ALU_XOR  = 4'h6;
   localparam logic [3:0] ALU_OR   = 4'h7;
   localparam logic [3:0] ALU_AND  = 4'h8;
   localparam logic [3:0] ALU_SLL  = 4'h9;
   localparam logic [3:0] ALU_SRL  = 4'hA;
   localparam logic [3:0] ALU_SRA  = 4'hB;

   localparam logic [1:0] A_PC    = 2'd0;
   localparam logic [1:0] A_OLDPC = 2'd1;
   localparam logic [1:0] A_RS1   = 2'd2;
   localparam logic [1:0] B_RS2   = 2'd0;
   localparam logic [1:0] B_FOUR  = 2'd1;
   localparam logic [1:0] B_IMM   = 2'd2;

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic [4:0] rd;
   logic       isR, isI, isLui, isAuipc, isLoad, isStore, isBranch, isJal, isJalr;
   logic       isLegal;
   logic [3:0] arithOp;
   logic [3:0] branchOp;
   logic       branchTaken;

   logic       memReq, memWe, memIord, irWe, pcWe, aluoutWe, rfWe;
   logic [1:0] pcSrc, aluSrcA, aluSrcB, wbSel;
   logic [3:0] aluCtrl;
   logic       waitCycle, timeoutHit;

   assign opcode   = bus.instr[6:0];
   assign funct3   = bus.instr[14:12];
   assign f7b5     = bus.instr[30];
   assign rd       = bus.instr[11:7];

   assign isR      = (opcode == OP_R);
   assign isI      = (opcode == OP_I);
   assign isLui    = (opcode == OP_LUI);
   assign isAuipc  = (opcode == OP_AUIPC);
   assign isLoad   = (opcode == OP_LOAD);
   assign isStore  = (opcode == OP_STORE);
   assign isBranch = (opcode == OP_BRANCH);
   assign isJal    = (opcode == OP_JAL);
   assign isJalr   = (opcode == OP_JALR);
   assign isLegal  = isR | isI | isLui | isAuipc | isLoad | isStore |
                     isBranch | isJal | isJalr;

   // Bit 30 only means sub for register-register adds; addi's bit 30 is immediate data.
   always_comb begin
      arithOp = ALU_ADD;
      case (funct3)
         3'b000:  arithOp = (isR && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  arithOp = ALU_SLL;
         3'b010:  arithOp = ALU_SLT;
         3'b011:  arithOp = ALU_SLTU;
         3'b100:  arithOp = ALU_XOR;
         3'b101:  arithOp = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  arithOp = ALU_OR;
         default: arithOp = ALU_AND;
      endcase
   end

   // funct3[2] picks compare vs equality, [1] unsigned compare, [0] inverts the sense.
   always_comb begin
      branchOp    = ALU_SUB;
      branchTaken = 1'b0;
      if (!funct3[2]) begin
         branchOp    = ALU_SUB;
         branchTaken = bus.alu_zero ^ funct3[0];
      end else begin
         branchOp    = funct3[1] ? ALU_SLTU : ALU_SLT;
         branchTaken = bus.alu_lsb ^ funct3[0];
      end
   end

   assign waitCycle  = memReq && !bus.mem_ready;
   assign timeoutHit = (MEM_TIMEOUT != 0) && waitCycle &&
                       (waitCnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      memReq   = 1'b0;
      memWe    = 1'b0;
      memIord  = 1'b0;
      irWe     = 1'b0;
      pcWe     = 1'b0;
      pcSrc    = 2'd0;
      aluCtrl  = ALU_ZERO;
      aluSrcA  = A_PC;
      aluSrcB  = B_RS2;
      aluoutWe = 1'b0;
      rfWe     = 1'b0;
      wbSel    = 2'd0;

      case (state_q)
         S_IF: begin
            memReq  = 1'b1;
            aluSrcA = A_PC;
            aluSrcB = B_FOUR;
            aluCtrl = ALU_ADD;
            if (bus.mem_ready) begin
               irWe    = 1'b1;
               pcWe    = 1'b1;
               pcSrc   = 2'd0;
               state_d = S_ID;
            end else if (timeoutHit) begin
               state_d = S_ERR;
            end
         end

         S_ID: begin
            aluSrcA  = A_OLDPC;
            aluSrcB  = B_IMM;
            aluCtrl  = ALU_ADD;
            aluoutWe = 1'b1;
            state_d  = isLegal ? S_EX : S_ERR;
         end

         S_EX: begin
            state_d = S_WB;
            if (isR || isI) begin
               aluSrcA  = A_RS1;
               aluSrcB  = isR ? B_RS2 : B_IMM;
               aluCtrl  = arithOp;
               aluoutWe = 1'b1;
            end else if (isLui) begin
               aluSrcB  = B_IMM;
               aluCtrl  = ALU_PASSB;
               aluoutWe = 1'b1;
            end else if (isAuipc) begin
               aluSrcA  = A_OLDPC;
               aluSrcB  = B_IMM;
               aluCtrl  = ALU_ADD;
               aluoutWe = 1'b1;
            end else if (isLoad || isStore) begin
               aluSrcA  = A_RS1;
               aluSrcB  = B_IMM;
               aluCtrl  = ALU_ADD;
               aluoutWe = 1'b1;
               state_d  = S_MEM;
            end else if (isBranch) begin
               aluSrcA = A_RS1;
               aluSrcB = B_RS2;
               aluCtrl = branchOp;
               pcWe    = branchTaken;
               pcSrc   = 2'd1;
               state_d = S_IF;
            end else if (isJal) begin
               pcWe  = 1'b1;
               pcSrc = 2'd1;
            end else if (isJalr) begin
               aluSrcA = A_RS1;
               aluSrcB = B_IMM;
               aluCtrl = ALU_ADD;
               pcWe    = 1'b1;
               pcSrc   = 2'd2;
            end else begin
               state_d = S_ERR;
            end
         end

         S_MEM: begin
            memReq  = 1'b1;
            memIord = 1'b1;
            memWe   = isStore;
            if (bus.mem_ready) begin
               state_d = isStore ? S_IF : S_WB;
            end else if (timeoutHit) begin
               state_d = S_ERR;
            end
         end

         S_WB: begin
            rfWe    = (rd != 5'd0);
            wbSel   = isLoad ? 2'd1 : ((isJal || isJalr) ? 2'd2 : 2'd0);
            state_d = S_IF;
         end

         S_ERR: begin
            state_d = S_ERR;
         end

         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // The wait counter only measures an unbroken stall within one state.
   always_comb begin
      if ((state_d != state_q) || !waitCycle) begin
         waitCnt_d = '0;
      end else begin
         waitCnt_d = waitCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= S_IF;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Holding reset silences every output, including a request already in flight.
   assign bus.mem_req   = rstn_i & memReq;
   assign bus.mem_we    = rstn_i & memWe;
   assign bus.mem_iord  = rstn_i & memIord;
   assign bus.ir_we     = rstn_i & irWe;
   assign bus.pc_we     = rstn_i & pcWe;
   assign bus.pc_src    = rstn_i ? pcSrc    : 2'd0;
   assign bus.alu_ctrl  = rstn_i ? aluCtrl  : 4'd0;
   assign bus.alu_src_a = rstn_i ? aluSrcA  : 2'd0;
   assign bus.alu_src_b = rstn_i ? aluSrcB  : 2'd0;
   assign bus.aluout_we = rstn_i & aluoutWe;
   assign bus.rf_we     = rstn_i & rfWe;
   assign bus.wb_sel    = rstn_i ? wbSel    : 2'd0;
   assign err_o         = rstn_i && (state_q == S_ERR);
   assign state_o       = rstn_i ? state_q  : 3'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks instruction classes through the FSM
// and checks strobes, memory stalls, timeout, illegal opcodes and reset.
module tb_mc_ctrl_fsm;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_SRAI  = 32'h4010D193;
   localparam logic [31:0] I_ADDIN = 32'hC0008193;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_LW    = 32'h0000A183;
   localparam logic [31:0] I_SW    = 32'h0020A023;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_ADDX0 = 32'h00208033;
   localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;

   logic       clk;
   logic       rstn;
   logic       err;
   logic [2:0] state;
   int         nChecks;
   int         nFails;

   mc_ctrl_fsm_if bus ();

   mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .bus     (bus.master),
      .err_o   (err),
      .state_o (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic rdy,
                                input logic z, input logic l);
      bus.instr     = ins;
      bus.mem_ready = rdy;
      bus.alu_zero  = z;
      bus.alu_lsb   = l;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts in S_IF with ready high; leaves the FSM in S_EX.
   task automatic fetchDecode(input logic [31:0] ins);
      applyStimulus(ins, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      rstn    = 1'b0;
      applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
      checkOutput("pre-reset mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("pre-reset state", 32'(state), 32'd0);
      tick();
      checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("reset ir_we", 32'(bus.ir_we), 32'd0);

      rstn = 1'b1;
      applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
      checkOutput("add IF state", 32'(state), 32'd0);
      checkOutput("add IF mem_req", 32'(bus.mem_req), 32'd1);
      checkOutput("add IF ir_we", 32'(bus.ir_we), 32'd1);
      checkOutput("add IF pc_we", 32'(bus.pc_we), 32'd1);
      checkOutput("add IF alu_ctrl", 32'(bus.alu_ctrl), 32'd1);
      checkOutput("add IF src_b", 32'(bus.alu_src_b), 32'd1);
      tick();
      checkOutput("add ID state", 32'(state), 32'd1);
      checkOutput("add ID aluout_we", 32'(bus.aluout_we), 32'd1);
      checkOutput("add ID src_a", 32'(bus.alu_src_a), 32'd1);
      checkOutput("add ID src_b", 32'(bus.alu_src_b), 32'd2);
      tick();
      checkOutput("add EX state", 32'(state), 32'd2);
      checkOutput("add EX alu_ctrl", 32'(bus.alu_ctrl), 32'd1);
      checkOutput("add EX src_a", 32'(bus.alu_src_a), 32'd2);
      checkOutput("add EX src_b", 32'(bus.alu_src_b), 32'd0);
      checkOutput("add EX rf_we", 32'(bus.rf_we), 32'd0);
      tick();
      checkOutput("add WB state", 32'(state), 32'd4);
      checkOutput("add WB rf_we", 32'(bus.rf_we), 32'd1);
      checkOutput("add WB wb_sel", 32'(bus.wb_sel), 32'd0);
      tick();
      checkOutput("add back IF", 32'(state), 32'd0);

      fetchDecode(I_SUB);
      checkOutput("sub EX alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      tick();
      tick();

      fetchDecode(I_SRAI);
      checkOutput("srai EX alu_ctrl", 32'(bus.alu_ctrl), 32'hB);
      checkOutput("srai EX src_b", 32'(bus.alu_src_b), 32'd2);
      tick();
      tick();

      fetchDecode(I_ADDIN);
      checkOutput("addi bit30 alu_ctrl", 32'(bus.alu_ctrl), 32'd1);
      tick();
      tick();

      fetchDecode(I_BEQ);
      applyStimulus(I_BEQ, 1'b1, 1'b1, 1'b0);
      checkOutput("beq taken pc_we", 32'(bus.pc_we), 32'd1);
      checkOutput("beq taken pc_src", 32'(bus.pc_src), 32'd1);
      checkOutput("beq alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
      tick();
      checkOutput("beq taken next", 32'(state), 32'd0);

      fetchDecode(I_BEQ);
      checkOutput("beq not-taken pc_we", 32'(bus.pc_we), 32'd0);
      tick();
      checkOutput("beq not-taken next", 32'(state), 32'd0);

      fetchDecode(I_LW);
      checkOutput("lw EX aluout_we", 32'(bus.aluout_we), 32'd1);
      applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("lw MEM state", 32'(state), 32'd3);
      checkOutput("lw MEM mem_req", 32'(bus.mem_req), 32'd1);
      checkOutput("lw MEM iord", 32'(bus.mem_iord), 32'd1);
      checkOutput("lw MEM mem_we", 32'(bus.mem_we), 32'd0);
      tick();
      checkOutput("lw wait2 mem_req", 32'(bus.mem_req), 32'd1);
      tick();
      checkOutput("lw wait3 state", 32'(state), 32'd3);
      checkOutput("lw wait3 mem_req", 32'(bus.mem_req), 32'd1);
      applyStimulus(I_LW, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("lw WB state", 32'(state), 32'd4);
      checkOutput("lw WB wb_sel", 32'(bus.wb_sel), 32'd1);
      checkOutput("lw WB rf_we", 32'(bus.rf_we), 32'd1);
      checkOutput("lw no err", 32'(err), 32'd0);
      tick();

      fetchDecode(I_SW);
      tick();
      checkOutput("sw MEM mem_we", 32'(bus.mem_we), 32'd1);
      checkOutput("sw MEM mem_req", 32'(bus.mem_req), 32'd1);
      tick();
      checkOutput("sw back IF", 32'(state), 32'd0);

      fetchDecode(I_JAL);
      checkOutput("jal EX pc_we", 32'(bus.pc_we), 32'd1);
      checkOutput("jal EX pc_src", 32'(bus.pc_src), 32'd1);
      tick();
      checkOutput("jal WB wb_sel", 32'(bus.wb_sel), 32'd2);
      checkOutput("jal WB rf_we", 32'(bus.rf_we), 32'd1);
      tick();

      fetchDecode(I_ADDX0);
      tick();
      checkOutput("x0 WB rf_we", 32'(bus.rf_we), 32'd0);
      tick();

      fetchDecode(I_LW);
      applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("rst-mem pre mem_req", 32'(bus.mem_req), 32'd1);
      rstn = 1'b0;
      #1;
      checkOutput("rst-mem mem_req", 32'(bus.mem_req), 32'd0);
      checkOutput("rst-mem iord", 32'(bus.mem_iord), 32'd0);
      checkOutput("rst-mem state", 32'(state), 32'd0);
      tick();
      rstn = 1'b1;
      applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
      checkOutput("rst-mem then IF", 32'(state), 32'd0);
      checkOutput("rst-mem IF mem_req", 32'(bus.mem_req), 32'd1);

      applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      checkOutput("timeout wait4 state", 32'(state), 32'd0);
      checkOutput("timeout wait4 err", 32'(err), 32'd0);
      tick();
      checkOutput("timeout state", 32'(state), 32'd7);
      checkOutput("timeout err", 32'(err), 32'd1);
      checkOutput("timeout mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      checkOutput("err sticky", 32'(err), 32'd1);
      rstn = 1'b0;
      #1;
      checkOutput("err in reset", 32'(err), 32'd0);
      tick();
      rstn = 1'b1;
      applyStimulus(I_ILL, 1'b1, 1'b0, 1'b0);
      checkOutput("post-err state", 32'(state), 32'd0);
      checkOutput("post-err err", 32'(err), 32'd0);

      tick();
      checkOutput("illegal ID state", 32'(state), 32'd1);
      tick();
      checkOutput("illegal ERR state", 32'(state), 32'd7);
      checkOutput("illegal err", 32'(err), 32'd1);
      checkOutput("illegal ERR pc_we", 32'(bus.pc_we), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
